// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator CPU control unit.
package cpu_pkg;

    // Instruction field positions (32-bit instruction word)
    localparam int unsigned IMM_BIT = 31;
    localparam int unsigned OPC_HI  = 30;
    localparam int unsigned OPC_LO  = 27;
    localparam int unsigned ADDR_HI = 26;
    localparam int unsigned SKIP_HI = 11;
    localparam int unsigned SKIP_LO = 10;

    typedef enum logic [3:0] {
        OpAdd   = 4'd0,
        OpHalt  = 4'd1,
        OpLoad  = 4'd2,
        OpStore = 4'd3,
        OpClear = 4'd4,
        OpSkip  = 4'd5,
        OpJump  = 4'd6,
        OpSub   = 4'd7,
        OpAnd   = 4'd8,
        OpOr    = 4'd9,
        OpNot   = 4'd10
    } opcode_e;

    // ALU function select codes
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluAdd = 3'b001;
    localparam logic [2:0] AluSub = 3'b010;
    localparam logic [2:0] AluOr  = 3'b100;

    // Skip condition codes (IR[11:10])
    localparam logic [1:0] SkipNeg   = 2'b00;
    localparam logic [1:0] SkipZero  = 2'b01;
    localparam logic [1:0] SkipPos   = 2'b10;
    localparam logic [1:0] SkipNever = 2'b11;

    typedef enum logic [3:0] {
        StIdle,
        StFAddr,
        StFWait,
        StFLatch,
        StDecode,
        StMAddr,
        StMWait,
        StMLatch,
        StExec,
        StWb,
        StSt,
        StHalt
    } state_e;

    // Where DECODE goes next
    typedef enum logic [1:0] {
        ClsMem,
        ClsExec,
        ClsStore,
        ClsHalt
    } cls_e;

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decoder: classifies IR[31:27] for the sequencer.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [4:0] ir_top,
    output cls_e       cls,
    output logic [2:0] alu_sel,
    output logic       use_imm,
    output logic       is_alu,
    output logic       is_load,
    output logic       illegal
);

    logic       imm;
    logic [3:0] opc;

    assign imm     = ir_top[IMM_BIT-OPC_LO];
    assign opc     = ir_top[OPC_HI-OPC_LO:0];
    assign use_imm = imm;

    // Opcode classification; immediate ALU ops bypass the operand read
    always_comb begin
        cls     = ClsExec;
        alu_sel = AluAdd;
        is_alu  = 1'b0;
        is_load = 1'b0;
        illegal = 1'b0;
        case (opc)
            OpAdd:   begin is_alu = 1'b1; alu_sel = AluAdd; end
            OpSub:   begin is_alu = 1'b1; alu_sel = AluSub; end
            OpAnd:   begin is_alu = 1'b1; alu_sel = AluAnd; end
            OpOr:    begin is_alu = 1'b1; alu_sel = AluOr;  end
            OpLoad:  begin is_load = 1'b1; cls = ClsMem; end
            OpStore: cls = ClsStore;
            OpHalt:  cls = ClsHalt;
            OpClear, OpSkip, OpJump, OpNot: cls = ClsExec;
            default: illegal = 1'b1;
        endcase
        if (is_alu && !imm) begin
            cls = ClsMem;
        end
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer for the accumulator CPU; owns PC, IR, MBR and AC.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 14,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h100)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [2:0]            alu_sel,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] ac,
    output logic                  halted,
    output logic                  illegal_op
);

    localparam logic [DATA_WIDTH-1:0] PcStep = DATA_WIDTH'(2);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [DATA_WIDTH-1:0] mbr_q, mbr_d;
    logic [DATA_WIDTH-1:0] ac_q, ac_d;

    cls_e       dec_cls;
    logic [2:0] dec_alu_sel;
    logic       dec_use_imm;
    logic       dec_is_alu;
    logic       dec_is_load;
    logic       dec_illegal;

    logic [3:0]            opc;
    logic [1:0]            skip_cond;
    logic                  skip_taken;
    logic                  ac_neg;
    logic                  ac_zero;
    logic [DATA_WIDTH-1:0] imm_val;

    cpu_decode u_decode (
        .ir_top  (ir_q[IMM_BIT:OPC_LO]),
        .cls     (dec_cls),
        .alu_sel (dec_alu_sel),
        .use_imm (dec_use_imm),
        .is_alu  (dec_is_alu),
        .is_load (dec_is_load),
        .illegal (dec_illegal)
    );

    assign opc       = ir_q[OPC_HI:OPC_LO];
    assign skip_cond = ir_q[SKIP_HI:SKIP_LO];
    // Address field doubles as zero-extended immediate and jump target
    assign imm_val   = {{(DATA_WIDTH-ADDR_HI-1){1'b0}}, ir_q[ADDR_HI:0]};
    assign ac_neg    = ac_q[DATA_WIDTH-1];
    assign ac_zero   = (ac_q == '0);

    // Signed skip condition on AC
    always_comb begin
        skip_taken = 1'b0;
        case (skip_cond)
            SkipNeg:   skip_taken = ac_neg;
            SkipZero:  skip_taken = ac_zero;
            SkipPos:   skip_taken = !ac_neg && !ac_zero;
            SkipNever: skip_taken = 1'b0;
            default:   skip_taken = 1'b0;
        endcase
    end

    // State and architectural registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            mbr_q   <= '0;
            ac_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mbr_q   <= mbr_d;
            ac_q    <= ac_d;
        end
    end

    // Next-state and register updates
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        mbr_d   = mbr_q;
        ac_d    = ac_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StFAddr;
            StFAddr:  state_d = StFWait;
            StFWait:  state_d = StFLatch;
            StFLatch: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + PcStep;
                state_d = StDecode;
            end
            StDecode: begin
                case (dec_cls)
                    ClsMem:   state_d = StMAddr;
                    ClsStore: state_d = StSt;
                    ClsHalt:  state_d = StHalt;
                    default:  state_d = StExec;
                endcase
            end
            StMAddr:  state_d = StMWait;
            StMWait:  state_d = StMLatch;
            StMLatch: begin
                mbr_d   = mem_rdata;
                state_d = dec_is_load ? StWb : StExec;
            end
            StExec: begin
                state_d = StFAddr;
                if (dec_is_alu) begin
                    state_d = StWb;
                end else begin
                    // Single-cycle register ops; undefined opcodes fall through as NOPs
                    case (opc)
                        OpClear: ac_d = '0;
                        OpNot:   ac_d = ~ac_q;
                        OpJump:  pc_d = imm_val;
                        OpSkip:  if (skip_taken) pc_d = pc_q + PcStep;
                        default: ;
                    endcase
                end
            end
            StWb: begin
                ac_d    = dec_is_load ? mbr_q : alu_out;
                state_d = StFAddr;
            end
            StSt:     state_d = StFAddr;
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase
    end

    // Memory and ALU drive decoded from the current state
    always_comb begin
        mem_cs   = 1'b0;
        mem_we   = 1'b0;
        mem_oe   = 1'b0;
        mem_addr = '0;
        alu_sel  = AluAdd;
        unique case (state_q)
            StFAddr, StFWait, StFLatch: begin
                mem_cs   = 1'b1;
                mem_oe   = 1'b1;
                mem_addr = pc_q[ADDR_WIDTH-1:0];
            end
            StMAddr, StMWait, StMLatch: begin
                mem_cs   = 1'b1;
                mem_oe   = 1'b1;
                mem_addr = ir_q[ADDR_WIDTH-1:0];
            end
            StSt: begin
                mem_cs   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = ir_q[ADDR_WIDTH-1:0];
            end
            // ALU result is combinational, so the select is held through WB
            StExec, StWb: alu_sel = dec_alu_sel;
            default: ;
        endcase
    end

    assign mem_wdata  = ac_q;
    assign alu_a      = ac_q;
    assign alu_b      = dec_use_imm ? imm_val : mbr_q;
    assign pc         = pc_q;
    assign ac         = ac_q;
    assign halted     = (state_q == StHalt);
    assign illegal_op = (state_q == StDecode) && dec_illegal;

endmodule
